// File: rtl/mem_router.sv
`default_nettype none
// ============================================================================
// Module   : mem_router
// Function : Single-outstanding router from one master port to NUM_REGIONS
//            address-decoded slave regions, with alignment and timeout errors.
// Revision : 1.0
// ============================================================================
module mem_router #(
    parameter int          NUM_REGIONS                    = 2,
    parameter logic [31:0] REGION_BEGIN [NUM_REGIONS-1:0] = '{32'h8000_0000, 32'h0040_0000},
    parameter int          REGION_BITS  [NUM_REGIONS-1:0] = '{17, 16},
    parameter int          TIMEOUT_CYCLES                 = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [31:0]               req_addr,
    input  logic                      req_write,
    input  logic [1:0]                req_size,
    input  logic [31:0]               req_wdata,
    input  logic [3:0]                req_wmask,
    output logic                      rsp_valid,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_error,
    output logic [NUM_REGIONS-1:0]    s_req_valid,
    input  logic [NUM_REGIONS-1:0]    s_req_ready,
    output logic [31:0]               s_addr,
    output logic                      s_write,
    output logic [31:0]               s_wdata,
    output logic [3:0]                s_wmask,
    input  logic [NUM_REGIONS-1:0]    s_rsp_valid,
    input  logic [32*NUM_REGIONS-1:0] s_rsp_rdata
);

    localparam int c_SEL_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    logic [1:0]         r_state;
    logic [31:0]        r_addr;
    logic               r_write;
    logic [31:0]        r_wdata;
    logic [3:0]         r_wmask;
    logic [c_SEL_W-1:0] r_sel;
    logic [31:0]        r_cnt;
    logic [31:0]        r_rdata;
    logic               r_err;

    logic [NUM_REGIONS-1:0] w_hit;
    logic [c_SEL_W-1:0]     w_sel;
    logic                   w_mapped;
    logic                   w_misaligned;
    logic [31:0]            w_base;
    logic                   w_sel_ready;
    logic                   w_sel_rsp;
    logic [31:0]            w_sel_rdata;
    logic [NUM_REGIONS-1:0] w_s_req_valid;
    logic [31:0]            w_cnt_next;
    logic                   w_timeout;

    // A region hits when the offset from its base fits in REGION_BITS bits.
    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_match
        if (REGION_BITS[g] >= 32) begin : g_full
            assign w_hit[g] = (req_addr >= REGION_BEGIN[g]);
        end else begin : g_part
            logic [31:0] w_off;
            assign w_off    = req_addr - REGION_BEGIN[g];
            assign w_hit[g] = (req_addr >= REGION_BEGIN[g]) && ((w_off >> REGION_BITS[g]) == 32'd0);
        end
    end

    always_comb begin
        w_sel    = '0;
        w_mapped = 1'b0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_sel    = c_SEL_W'(i);
                w_mapped = 1'b1;
            end
        end
    end

    assign w_misaligned = (req_size == 2'd3) ||
                          ((req_size == 2'd1) && req_addr[0]) ||
                          ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

    always_comb begin
        w_base        = '0;
        w_sel_ready   = 1'b0;
        w_sel_rsp     = 1'b0;
        w_sel_rdata   = '0;
        w_s_req_valid = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (r_sel == c_SEL_W'(i)) begin
                w_base           = REGION_BEGIN[i];
                w_sel_ready      = s_req_ready[i];
                w_sel_rsp        = s_rsp_valid[i];
                w_sel_rdata      = s_rsp_rdata[i*32 +: 32];
                w_s_req_valid[i] = (r_state == c_ISSUE);
            end
        end
    end

    assign w_cnt_next = r_cnt + 32'd1;
    assign w_timeout  = (w_cnt_next == 32'(TIMEOUT_CYCLES));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_write <= req_write;
                        r_wdata <= req_wdata;
                        r_wmask <= req_wmask;
                        r_sel   <= w_sel;
                        r_cnt   <= '0;
                        r_rdata <= '0;
                        if (!w_mapped || w_misaligned) begin
                            r_err   <= 1'b1;
                            r_state <= c_RESP;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= c_ISSUE;
                        end
                    end
                end
                c_ISSUE: begin
                    r_cnt <= w_cnt_next;
                    if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                        r_state <= c_RESP;
                    end else if (w_sel_ready) begin
                        r_state <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    r_cnt <= w_cnt_next;
                    // A response arriving on the timeout cycle takes priority.
                    if (w_sel_rsp) begin
                        r_rdata <= w_sel_rdata;
                        r_err   <= 1'b0;
                        r_state <= c_RESP;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                        r_state <= c_RESP;
                    end
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = (r_state == c_IDLE);
    assign rsp_valid   = (r_state == c_RESP);
    assign rsp_rdata   = r_rdata;
    assign rsp_error   = r_err;
    assign s_req_valid = w_s_req_valid;
    assign s_addr      = r_addr - w_base;
    assign s_write     = r_write;
    assign s_wdata     = r_wdata;
    assign s_wmask     = r_wmask;

endmodule
`default_nettype wire

// File: tb/tb_mem_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_router
// Function : Table-driven and randomized self-checking bench for mem_router.
// Revision : 1.0
// ============================================================================
module tb_mem_router;

    localparam int          NR    = 2;
    localparam int          T     = 255;
    localparam int          NEVER = 1000;
    // Region 0 is the 128 KiB window at 0x80000000, region 1 the 64 KiB one at 0x00400000.
    localparam logic [31:0] M_BEGIN [NR-1:0] = '{32'h0040_0000, 32'h8000_0000};
    localparam int          M_BITS  [NR-1:0] = '{16, 17};

    logic              clock = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic              req_write;
    logic [1:0]        req_size;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wmask;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_error;
    logic [NR-1:0]     s_req_valid;
    logic [NR-1:0]     s_req_ready;
    logic [31:0]       s_addr;
    logic              s_write;
    logic [31:0]       s_wdata;
    logic [3:0]        s_wmask;
    logic [NR-1:0]     s_rsp_valid;
    logic [32*NR-1:0]  s_rsp_rdata;

    int n_pass  = 0;
    int n_total = 0;

    mem_router #(
        .NUM_REGIONS    (NR),
        .REGION_BEGIN   (M_BEGIN),
        .REGION_BITS    (M_BITS),
        .TIMEOUT_CYCLES (T)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_wdata   (req_wdata),
        .req_wmask   (req_wmask),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .s_req_valid (s_req_valid),
        .s_req_ready (s_req_ready),
        .s_addr      (s_addr),
        .s_write     (s_write),
        .s_wdata     (s_wdata),
        .s_wmask     (s_wmask),
        .s_rsp_valid (s_rsp_valid),
        .s_rsp_rdata (s_rsp_rdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          ready_at;   // cycle (0 = accept cycle) the slave raises ready
        int          rsp_at;     // cycle the slave raises its response
        logic [31:0] sdata;
        int          exp_cyc;    // cycle rsp_valid is expected
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_reg;    // -1: no slave activity
        logic [31:0] exp_saddr;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] addr, input logic [1:0] size, input logic write,
                                input logic [31:0] wdata, input logic [3:0] wmask, input int ready_at,
                                input int rsp_at, input logic [31:0] sdata, input int exp_cyc,
                                input logic exp_err, input logic [31:0] exp_rdata, input int exp_reg,
                                input logic [31:0] exp_saddr);
        vec_t v;
        v.addr = addr; v.size = size; v.write = write; v.wdata = wdata; v.wmask = wmask;
        v.ready_at = ready_at; v.rsp_at = rsp_at; v.sdata = sdata;
        v.exp_cyc = exp_cyc; v.exp_err = exp_err; v.exp_rdata = exp_rdata;
        v.exp_reg = exp_reg; v.exp_saddr = exp_saddr;
        return v;
    endfunction

    // Reference model: address windows, alignment and timeout rules in plain arithmetic.
    function automatic vec_t model(input vec_t vin);
        vec_t            v;
        longint unsigned a, lo, hi;
        bit              mis;
        v = vin;
        v.exp_reg   = -1;
        v.exp_saddr = '0;
        a = 64'(v.addr);
        for (int i = 0; i < NR; i++) begin
            lo = 64'(M_BEGIN[i]);
            hi = lo + (64'd1 << M_BITS[i]) - 64'd1;
            if (v.exp_reg < 0 && a >= lo && a <= hi) begin
                v.exp_reg   = i;
                v.exp_saddr = 32'(a - lo);
            end
        end
        mis = (v.size == 2'd3) || (v.size == 2'd1 && (v.addr % 2) != 0) ||
              (v.size == 2'd2 && (v.addr % 4) != 0);
        if (v.exp_reg < 0 || mis) begin
            v.exp_reg = -1; v.exp_saddr = '0;
            v.exp_cyc = 1;  v.exp_err = 1'b1; v.exp_rdata = '0;
        end else if (v.ready_at < T && v.rsp_at <= T) begin
            v.exp_cyc = v.rsp_at + 1; v.exp_err = 1'b0; v.exp_rdata = v.sdata;
        end else begin
            v.exp_cyc = T + 1; v.exp_err = 1'b1; v.exp_rdata = '0;
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        logic [NR-1:0] exp_oh, exp_s;
        int            got_cyc, last_issue;
        logic [31:0]   got_rd;
        logic          got_err, done, sreq_ok, ready0, fld_ok;
        exp_oh     = (v.exp_reg >= 0) ? (NR'(1) << v.exp_reg) : '0;
        last_issue = (v.ready_at < T) ? v.ready_at : T;
        got_cyc = -1; got_rd = '0; got_err = 1'b0; done = 1'b0;
        sreq_ok = 1'b1; ready0 = 1'b0; fld_ok = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b1; req_addr = v.addr; req_size = v.size; req_write = v.write;
        req_wdata = v.wdata; req_wmask = v.wmask;
        for (int k = 0; k < 300 && !done; k++) begin
            s_req_ready = (k == v.ready_at) ? exp_oh : '0;
            s_rsp_rdata = {$urandom, $urandom};
            s_rsp_valid = NR'($urandom) & ~exp_oh;
            if (k == v.rsp_at && exp_oh != '0) begin
                s_rsp_valid = s_rsp_valid | exp_oh;
                s_rsp_rdata[v.exp_reg*32 +: 32] = v.sdata;
            end else if (k <= v.ready_at && $urandom_range(0, 1) == 1) begin
                s_rsp_valid = s_rsp_valid | exp_oh;
            end
            @(negedge clock);
            if (k == 0) ready0 = req_ready;
            exp_s = (k >= 1 && k <= last_issue) ? exp_oh : '0;
            if (s_req_valid !== exp_s) sreq_ok = 1'b0;
            if (k == 1 && exp_oh != '0) begin
                if (s_addr !== v.exp_saddr || s_write !== v.write) fld_ok = 1'b0;
                if (v.write && (s_wdata !== v.wdata || s_wmask !== v.wmask)) fld_ok = 1'b0;
            end
            if (rsp_valid === 1'b1) begin
                done = 1'b1; got_cyc = k; got_rd = rsp_rdata; got_err = rsp_error;
            end
            @(posedge clock); #1;
            if (k == 0) req_valid = 1'b0;
        end
        s_req_ready = '0; s_rsp_valid = '0;
        @(negedge clock);
        check({tag, " ready_at_accept"}, 32'(ready0), 32'd1);
        check({tag, " rsp_cycle"}, 32'(got_cyc), 32'(v.exp_cyc));
        check({tag, " rsp_error"}, 32'(got_err), 32'(v.exp_err));
        check({tag, " rsp_rdata"}, got_rd, v.exp_rdata);
        check({tag, " s_req_valid_pattern"}, 32'(sreq_ok), 32'd1);
        if (exp_oh != '0) check({tag, " slave_fields"}, 32'(fld_ok), 32'd1);
        check({tag, " idle_after_rsp"}, {30'd0, rsp_valid, req_ready}, 32'd1);
    endtask

    task automatic pulse_reset();
        @(posedge clock); #1; reset = 1'b1;
        @(posedge clock); #1; reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [15];
        vec_t        v;
        logic [31:0] edges [6];
        logic        bad;

        tbl[0]  = mk(32'h0040_0010, 2, 0, 0, 0, 1, 2, 32'hDEAD_BEEF, 3, 0, 32'hDEAD_BEEF, 1, 32'h10);
        tbl[1]  = mk(32'h8001_FFFC, 2, 1, 32'h1234_5678, 4'hF, 1, 2, 32'h0, 3, 0, 32'h0, 0, 32'h1_FFFC);
        tbl[2]  = mk(32'h8002_0000, 2, 1, 32'h1111_2222, 4'hF, 1, 2, 32'h5, 1, 1, 32'h0, -1, 32'h0);
        tbl[3]  = mk(32'h0040_0002, 2, 0, 0, 0, 1, 2, 32'h5, 1, 1, 32'h0, -1, 32'h0);
        tbl[4]  = mk(32'h0040_FFFF, 0, 0, 0, 0, 2, 5, 32'h0000_00A5, 6, 0, 32'h0000_00A5, 1, 32'hFFFF);
        tbl[5]  = mk(32'h0041_0000, 0, 0, 0, 0, 1, 2, 32'h5, 1, 1, 32'h0, -1, 32'h0);
        tbl[6]  = mk(32'h8000_0001, 1, 0, 0, 0, 1, 2, 32'h5, 1, 1, 32'h0, -1, 32'h0);
        tbl[7]  = mk(32'h8000_0002, 1, 0, 0, 0, 1, 3, 32'h0000_BEEF, 4, 0, 32'h0000_BEEF, 0, 32'h2);
        tbl[8]  = mk(32'h8000_0000, 3, 0, 0, 0, 1, 2, 32'h5, 1, 1, 32'h0, -1, 32'h0);
        tbl[9]  = mk(32'h7FFF_FFFC, 2, 0, 0, 0, 1, 2, 32'h5, 1, 1, 32'h0, -1, 32'h0);
        tbl[10] = mk(32'h8000_0100, 2, 0, 0, 0, NEVER, NEVER, 32'h5, 256, 1, 32'h0, 0, 32'h100);
        tbl[11] = mk(32'h8000_0104, 2, 0, 0, 0, 1, NEVER, 32'h5, 256, 1, 32'h0, 0, 32'h104);
        tbl[12] = mk(32'h8000_0108, 2, 0, 0, 0, 1, 255, 32'hCAFE_F00D, 256, 0, 32'hCAFE_F00D, 0, 32'h108);
        tbl[13] = mk(32'h0040_0200, 2, 0, 0, 0, 1, 256, 32'h7777_7777, 256, 1, 32'h0, 1, 32'h200);
        tbl[14] = mk(32'h0040_0204, 2, 1, 32'hABCD_0000, 4'hC, 254, 255, 32'h0BAD_F00D, 256, 0, 32'h0BAD_F00D, 1, 32'h204);

        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_size = '0;
        req_wdata = '0; req_wmask = '0; s_req_ready = '0; s_rsp_valid = '0; s_rsp_rdata = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_error", 32'(rsp_error), 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'd0);
        check("reset s_req_valid", 32'(s_req_valid), 32'd0);

        for (int i = 0; i < 15; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

        // Reset must clear latched response data and error flag.
        apply_vec(tbl[0], "pre_rst_data");
        pulse_reset();
        check("reset clears rsp_rdata", rsp_rdata, 32'd0);
        apply_vec(tbl[3], "pre_rst_err");
        pulse_reset();
        check("reset clears rsp_error", 32'(rsp_error), 32'd0);

        // Reset while waiting on the slave abandons the transaction silently.
        @(posedge clock); #1;
        req_valid = 1'b1; req_addr = 32'h0040_0020; req_size = 2'd2; req_write = 1'b0;
        @(posedge clock); #1;
        req_valid = 1'b0; s_req_ready = 2'b10;
        @(negedge clock);
        check("rst_wait issue", 32'(s_req_valid), 32'h2);
        @(posedge clock); #1;
        s_req_ready = '0; reset = 1'b1;
        @(negedge clock);
        check("rst_wait in_wait rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_wait req_ready", 32'(req_ready), 32'd1);
        bad = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clock); #1;
            s_rsp_valid = '1; s_rsp_rdata = {$urandom, $urandom};
            @(negedge clock);
            if (rsp_valid !== 1'b0 || s_req_valid !== '0 || req_ready !== 1'b1) bad = 1'b1;
        end
        @(posedge clock); #1;
        s_rsp_valid = '0;
        check("rst_wait stray rsp ignored", 32'(bad), 32'd0);
        apply_vec(tbl[0], "after_rst");

        edges = '{32'h003F_FFFC, 32'h0041_0000, 32'h8001_FFFE, 32'h8002_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFC};
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       v.addr = 32'h8000_0000 + 32'($urandom_range(0, 32'h1_FFFF));
                1:       v.addr = 32'h0040_0000 + 32'($urandom_range(0, 32'hFFFF));
                2:       v.addr = edges[$urandom_range(0, 5)];
                default: v.addr = $urandom;
            endcase
            v.size     = 2'($urandom_range(0, 3));
            v.write    = 1'($urandom_range(0, 1));
            v.wdata    = $urandom;
            v.wmask    = 4'($urandom);
            v.ready_at = $urandom_range(1, 3);
            v.rsp_at   = v.ready_at + $urandom_range(1, 3);
            v.sdata    = $urandom;
            apply_vec(model(v), $sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
